// File: rtl/frame_buf_pkg.sv
// Shared types and helpers for the sliding-window frame buffer.
package frame_buf_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    STALL  = 2'd2
  } fbuf_state_e;

  // Advance a circular pointer by inc, wrapping at depth (inc <= depth).
  function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + inc;
    if (sum >= depth) begin
      sum = sum - depth;
    end
    return sum;
  endfunction

endpackage

// File: rtl/frame_buf_mem.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Each channel gets its own array so lanes map onto independent RAM columns.
module frame_buf_mem #(
  parameter int DEPTH      = 120,
  parameter int AW         = 7,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [AW-1:0]                waddr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
  input  logic                         re,
  input  logic [AW-1:0]                raddr,
  output logic [NUM_CH*DATA_WIDTH-1:0] rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] rdata_reg;

      // Write port: store this channel's lane of the accepted sample.
      always_ff @(posedge clk) begin
        if (we) begin
          mem[waddr] <= wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      // Read port: output register only updates on an accepted read, so it holds otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg <= '0;
        end else if (re) begin
          rdata_reg <= mem[raddr];
        end
      end

      assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/frame_window_buf.sv
// Sliding-window sample buffer: publishes a stable POPSIZE-sample window every
// FRAME_SIZE accepted samples, stalling the writer until the consumer releases.
module frame_window_buf
  import frame_buf_pkg::*;
#(
  parameter int POPSIZE    = 100,
  parameter int FRAME_SIZE = 20,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic                         data_rdy,
  output logic                         in_ready,
  input  logic                         rd_rqst,
  input  logic [$clog2(POPSIZE)-1:0]   read_addr,
  output logic                         data_vld,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         rd_err,
  input  logic                         win_done,
  output logic                         new_data,
  output logic [CNT_W-1:0]             frame_cnt
);

  localparam int DEPTH = POPSIZE + FRAME_SIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam int RAW   = $clog2(POPSIZE);

  fbuf_state_e      state_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    win_base_reg;
  logic [AW-1:0]    fill_cnt_reg;
  logic             rel_reg;
  logic [CNT_W-1:0] frame_cnt_reg;
  logic             new_data_reg;
  logic             data_vld_reg;
  logic             rd_err_reg;

  logic             accept;
  logic             addr_ok;
  logic             rd_ok;
  logic [AW:0]      rd_sum;
  logic [AW-1:0]    rd_addr;

  // The writer only stops while a full frame waits on the consumer.
  assign in_ready = ~rst & (state_reg != STALL);
  assign accept   = data_rdy & in_ready;

  // When POPSIZE fills the address space every index is in range.
  generate
    if (POPSIZE == (1 << RAW)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_cmp
      assign addr_ok = (read_addr < RAW'(POPSIZE));
    end
  endgenerate

  assign rd_ok = rd_rqst & (state_reg != FILL) & addr_ok;

  // Window index -> physical slot, one conditional subtract suffices since both terms < DEPTH.
  assign rd_sum  = {1'b0, win_base_reg} + (AW+1)'(read_addr);
  assign rd_addr = (rd_sum >= (AW+1)'(DEPTH)) ? AW'(rd_sum - (AW+1)'(DEPTH)) : AW'(rd_sum);

  frame_buf_mem #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (wr_ptr_reg),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rd_addr),
    .rdata (data_out)
  );

  // Window FSM, write pointer, release tracking and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FILL;
      wr_ptr_reg    <= '0;
      win_base_reg  <= '0;
      fill_cnt_reg  <= '0;
      rel_reg       <= 1'b0;
      frame_cnt_reg <= '0;
      new_data_reg  <= 1'b0;
      data_vld_reg  <= 1'b0;
      rd_err_reg    <= 1'b0;
    end else begin
      new_data_reg <= 1'b0;
      data_vld_reg <= rd_ok;
      rd_err_reg   <= rd_rqst & ~rd_ok;

      if (accept) begin
        wr_ptr_reg   <= AW'(ptr_wrap(32'(wr_ptr_reg), 1, DEPTH));
        fill_cnt_reg <= fill_cnt_reg + AW'(1);
      end

      case (state_reg)
        FILL: begin
          // First window sits at slot 0; win_done is meaningless before it exists.
          if (accept && fill_cnt_reg == AW'(POPSIZE - 1)) begin
            win_base_reg  <= '0;
            fill_cnt_reg  <= '0;
            rel_reg       <= 1'b0;
            frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            new_data_reg  <= 1'b1;
            state_reg     <= STREAM;
          end
        end
        STREAM: begin
          if (accept && fill_cnt_reg == AW'(FRAME_SIZE - 1)) begin
            fill_cnt_reg <= '0;
            // A release arriving in this same cycle frees the old window; new one starts unreleased.
            if (rel_reg || win_done) begin
              win_base_reg  <= AW'(ptr_wrap(32'(win_base_reg), FRAME_SIZE, DEPTH));
              rel_reg       <= 1'b0;
              frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
              new_data_reg  <= 1'b1;
            end else begin
              state_reg <= STALL;
            end
          end else if (win_done) begin
            rel_reg <= 1'b1;
          end
        end
        STALL: begin
          if (win_done) begin
            win_base_reg  <= AW'(ptr_wrap(32'(win_base_reg), FRAME_SIZE, DEPTH));
            rel_reg       <= 1'b0;
            frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            new_data_reg  <= 1'b1;
            state_reg     <= STREAM;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign new_data  = new_data_reg;
  assign data_vld  = data_vld_reg;
  assign rd_err    = rd_err_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule
